lcd_view_scheduler: RTL
=======================

Name: lcd_view_scheduler

Overview:
Sequences the display content fed to LCD1602_CONTROLLER (face index plus food/joy/energy bars). It runs a timed face animation and arbitrates stat-update requests from two requesters, the game FSM (high priority) and the debug/button path (low priority). Its outputs drive the controller's face/food_value/joy_value/energy_value inputs directly and replace the free-running test sequencer.

Parameters:
NUM_FACES, 9, number of face glyph sets; face width = $clog2(NUM_FACES)
MAX_VALUE, 5, full-scale stat value; stat width SW = $clog2(MAX_VALUE+1)
TICK_DIV, 800000, clk cycles per display tick (16 ms at 50 MHz)
DWELL_TICKS, 80, ticks each animation frame is held

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
anim_start  in  1  pulse: start animation at anim_first
anim_stop  in  1  pulse: stop animation, keep current face
anim_first  in  $clog2(NUM_FACES)  first frame index
anim_last  in  $clog2(NUM_FACES)  last frame index
anim_loop  in  1  1 = restart at anim_first after anim_last
g_req  in  1  game requester stat write request (level, held until ack)
g_sel  in  2  0 food, 1 joy, 2 energy, 3 invalid
g_value  in  SW  requested value
d_req  in  1  debug requester request (level)
d_sel  in  2  as g_sel
d_value  in  SW  as g_value
g_ack  out  1  one-cycle grant pulse for game request
d_ack  out  1  one-cycle grant pulse for debug request
sel_err  out  1  one-cycle pulse when a granted request had sel=3
face  out  $clog2(NUM_FACES)  face index to LCD controller
food_value  out  SW  food bar value
joy_value  out  SW  joy bar value
energy_value  out  SW  energy bar value
anim_busy  out  1  high while in ANIM
frame_strobe  out  1  one-cycle pulse each time face changes due to animation

Behaviour:
- Reset (async, active-high): face=0, food/joy/energy=MAX_VALUE, all acks/strobes=0, anim_busy=0, FSM=IDLE, tick and dwell counters=0.
- Tick: counter 0..TICK_DIV-1 runs continuously; tick pulses 1 cycle when counter==TICK_DIV-1, then wraps to 0.
- FSM states IDLE, ANIM.
- IDLE: anim_start -> face<=anim_first (clamped to 0 if >=NUM_FACES), dwell<=0, ANIM, anim_busy=1 next cycle. No frame_strobe on start.
- ANIM: on each tick dwell++; when dwell==DWELL_TICKS-1 on a tick: dwell<=0, frame_strobe=1 and
  - face!=anim_last: face<=face+1, wrapping NUM_FACES-1 -> 0 (so first>last is legal);
  - face==anim_last and anim_loop: face<=anim_first;
  - face==anim_last and !anim_loop: face unchanged, no strobe, go IDLE.
- anim_stop in ANIM -> IDLE next cycle, face held. anim_start in ANIM restarts (same as from IDLE). start and stop in same cycle: start wins.
- anim_first/anim_last/anim_loop sampled live every frame advance.
- Arbitration, one grant per cycle, fixed priority game > debug. Grant cycle: the ack pulses and the selected stat register updates on the same edge (1-cycle latency from req). Value > MAX_VALUE saturates to MAX_VALUE. sel=3: ack still pulses, no stat changes, sel_err pulses.
- Requester must deassert req the cycle after ack; req still high after ack is treated as a new request (re-granted).
- Both requesting continuously: game granted every cycle, debug starves (documented, accepted).
- Stat path independent of FSM: a grant during ANIM or coincident with a frame advance both take effect.
- Reset mid-animation or mid-request: everything returns to reset values immediately; no ack is issued for the pending request.

Decomposition:
- Package lcd_view_pkg: STAT_FOOD=0, STAT_JOY=1, STAT_ENERGY=2, STAT_INVALID=3; FSM state encoding (IDLE, ANIM).
- Sub-module lcd_tick_gen (parameter TICK_DIV; clk, reset, tick): the tick counter.

Test Plan:
(Bench parameters: TICK_DIV=4, DWELL_TICKS=2, NUM_FACES=9, MAX_VALUE=5.)
- Reset release -> face=0, all stats=5, anim_busy=0. Assert reset mid-ANIM at face=3 -> face=0 at once, anim_busy=0.
- anim_start with first=2, last=4, loop=0 -> faces 2,3,4 with 8 clk between changes and 2 frame_strobes, then IDLE with face=4.
- first=7, last=1, loop=1 -> sequence 7,8,0,1,7,8... Then anim_stop -> face frozen, anim_busy=0 next cycle.
- g_req sel=1 val=2 and d_req sel=0 val=3 raised in the same cycle -> g_ack with joy=2 first; d_ack one cycle later with food=3.
- d_req sel=2 val=7 -> energy=5 (saturated). g_req sel=3 -> g_ack and sel_err pulse, stats unchanged.
- Stat grant on the same edge as a frame advance during ANIM -> both the face and the stat update on that edge.

Source files
------------

// File: rtl/lcd_view_pkg.sv
// lcd_view_pkg: stat selector codes and scheduler state encoding shared by the LCD view logic
package lcd_view_pkg;
    typedef enum logic [1:0] {
        STAT_FOOD    = 2'd0,
        STAT_JOY     = 2'd1,
        STAT_ENERGY  = 2'd2,
        STAT_INVALID = 2'd3
    } stat_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        ANIM = 1'b1
    } view_state_e;
endpackage

// File: rtl/lcd_tick_gen.sv
// lcd_tick_gen: free-running divider producing a one-cycle display tick every TICK_DIV clocks
module lcd_tick_gen #(
    parameter int TICK_DIV = 800000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == CW'(TICK_DIV - 1);

    always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lcd_view_scheduler.sv
// lcd_view_scheduler: timed face animation plus fixed-priority (game > debug) stat-bar writer
module lcd_view_scheduler
    import lcd_view_pkg::*;
#(
    parameter int NUM_FACES   = 9,
    parameter int MAX_VALUE   = 5,
    parameter int TICK_DIV    = 800000,
    parameter int DWELL_TICKS = 80
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             anim_start,
    input  logic                             anim_stop,
    input  logic [$clog2(NUM_FACES)-1:0]     anim_first,
    input  logic [$clog2(NUM_FACES)-1:0]     anim_last,
    input  logic                             anim_loop,
    input  logic                             g_req,
    input  logic [1:0]                       g_sel,
    input  logic [$clog2(MAX_VALUE+1)-1:0]   g_value,
    input  logic                             d_req,
    input  logic [1:0]                       d_sel,
    input  logic [$clog2(MAX_VALUE+1)-1:0]   d_value,
    output logic                             g_ack,
    output logic                             d_ack,
    output logic                             sel_err,
    output logic [$clog2(NUM_FACES)-1:0]     face,
    output logic [$clog2(MAX_VALUE+1)-1:0]   food_value,
    output logic [$clog2(MAX_VALUE+1)-1:0]   joy_value,
    output logic [$clog2(MAX_VALUE+1)-1:0]   energy_value,
    output logic                             anim_busy,
    output logic                             frame_strobe
);
    localparam int FW = $clog2(NUM_FACES);
    localparam int SW = $clog2(MAX_VALUE + 1);
    localparam int DW = $clog2(DWELL_TICKS + 1);

    view_state_e   state_q, state_d;
    logic [FW-1:0] face_q, face_d, first_c;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          strobe_q, strobe_d;
    logic [SW-1:0] food_q, food_d, joy_q, joy_d, energy_q, energy_d, raw_c, val_c;
    logic [1:0]    sel_c;
    logic          gnt_c, g_ack_q, g_ack_d, d_ack_q, d_ack_d, sel_err_q, sel_err_d;
    logic          tick;

    lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        first_c  = (int'(anim_first) >= NUM_FACES) ? '0 : anim_first;
        state_d  = state_q;
        face_d   = face_q;
        dwell_d  = dwell_q;
        strobe_d = 1'b0;
        if (anim_start) begin
            state_d = ANIM;
            face_d  = first_c;
            dwell_d = '0;
        end else if (state_q == ANIM) begin
            if (anim_stop)
                state_d = IDLE;
            else if (tick) begin
                if (dwell_q == DW'(DWELL_TICKS - 1)) begin
                    dwell_d = '0;
                    if (face_q != anim_last) begin
                        face_d   = (face_q == FW'(NUM_FACES - 1)) ? '0 : face_q + 1'b1;
                        strobe_d = 1'b1;
                    end else if (anim_loop) begin
                        face_d   = first_c;
                        strobe_d = 1'b1;
                    end else
                        state_d = IDLE;
                end else
                    dwell_d = dwell_q + 1'b1;
            end
        end
    end

    // Game always wins; debug is granted only in cycles the game is silent.
    always_comb begin
        gnt_c     = g_req | d_req;
        sel_c     = g_req ? g_sel : d_sel;
        raw_c     = g_req ? g_value : d_value;
        val_c     = (int'(raw_c) > MAX_VALUE) ? SW'(MAX_VALUE) : raw_c;
        g_ack_d   = g_req;
        d_ack_d   = d_req & ~g_req;
        sel_err_d = gnt_c && sel_c == STAT_INVALID;
        food_d    = (gnt_c && sel_c == STAT_FOOD) ? val_c : food_q;
        joy_d     = (gnt_c && sel_c == STAT_JOY) ? val_c : joy_q;
        energy_d  = (gnt_c && sel_c == STAT_ENERGY) ? val_c : energy_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            face_q    <= '0;
            dwell_q   <= '0;
            strobe_q  <= 1'b0;
            food_q    <= SW'(MAX_VALUE);
            joy_q     <= SW'(MAX_VALUE);
            energy_q  <= SW'(MAX_VALUE);
            g_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            face_q    <= face_d;
            dwell_q   <= dwell_d;
            strobe_q  <= strobe_d;
            food_q    <= food_d;
            joy_q     <= joy_d;
            energy_q  <= energy_d;
            g_ack_q   <= g_ack_d;
            d_ack_q   <= d_ack_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign face         = face_q;
    assign food_value   = food_q;
    assign joy_value    = joy_q;
    assign energy_value = energy_q;
    assign anim_busy    = state_q == ANIM;
    assign frame_strobe = strobe_q;
    assign g_ack        = g_ack_q;
    assign d_ack        = d_ack_q;
    assign sel_err      = sel_err_q;
endmodule
